// File: rtl/range_check_arbiter.sv
// range_check_arbiter: sequences the allocated-range buffer. Allocation
// records are queued in a small FIFO and drained one per cycle into the
// buffer. NUM_REQ checkers share the buffer's single lookup port through a
// round-robin arbiter. A write-streak limit keeps lookups from starving.
`timescale 1ns/1ps

module range_check_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int REC_FIFO_DEPTH = 4,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    flush_i,
  input  logic                    hold_i,
  input  logic                    rec_valid_i,
  output logic                    rec_ready_o,
  input  logic [31:0]             rec_first_i,
  input  logic [31:0]             rec_last_i,
  input  logic [NUM_REQ-1:0]      chk_valid_i,
  output logic [NUM_REQ-1:0]      chk_ready_o,
  input  logic [32*NUM_REQ-1:0]   chk_addr_i,
  output logic [NUM_REQ-1:0]      rsp_valid_o,
  output logic                    rsp_hit_o,
  output logic [15:0]             miss_cnt_o,
  output logic                    buf_en_write_o,
  output logic [31:0]             buf_addr_first_o,
  output logic [31:0]             buf_addr_last_o,
  output logic                    buf_find_o,
  output logic [31:0]             buf_find_addr_o,
  input  logic                    buf_addr_in_range_i
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int AW    = $clog2(REC_FIFO_DEPTH);
  localparam int SW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0]  STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [PTR_W:0] NUM_REQ_W  = (PTR_W + 1)'(NUM_REQ);

  // The operation performed in the current cycle.
  typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_CHECK} state_e;

  state_e                 w_state;
  state_e                 r_state;
  logic                   r_alive;
  logic [31:0]            r_mem_first [REC_FIFO_DEPTH];
  logic [31:0]            r_mem_last  [REC_FIFO_DEPTH];
  logic [AW:0]            r_wr_ptr;
  logic [AW:0]            r_rd_ptr;
  logic [PTR_W-1:0]       r_rr;
  logic [SW-1:0]          r_starve;
  logic [NUM_REQ-1:0]     r_grant;
  logic                   r_hit;
  logic [15:0]            r_miss;

  logic                   w_empty;
  logic                   w_full;
  logic                   w_push;
  logic                   w_any_req;
  logic [2*NUM_REQ-1:0]   w_req_dbl;
  logic [NUM_REQ-1:0]     w_req_rot;
  logic [PTR_W-1:0]       w_ofs;
  logic [PTR_W:0]         w_sum;
  logic [PTR_W-1:0]       w_gnt;
  logic [PTR_W:0]         w_rr_nxt;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push    = rec_valid_i & rec_ready_o;
  assign w_any_req = |chk_valid_i;
  assign w_req_dbl = {chk_valid_i, chk_valid_i};
  assign w_req_rot = NUM_REQ'(w_req_dbl >> r_rr);

  // Round-robin pick: rotate requests so rr_ptr sits at bit 0, take the
  // lowest set bit, then rotate the offset back to a requester index.
  // NOTE: every variable gets a default at the top of an always_comb so no
  // path leaves it unassigned; otherwise a latch would be inferred.
  always_comb begin
    w_ofs = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_req_rot[k]) w_ofs = PTR_W'(k);
    end
    w_sum = {1'b0, r_rr} + {1'b0, w_ofs};
    if (w_sum >= NUM_REQ_W) w_sum = w_sum - NUM_REQ_W;
    w_gnt    = w_sum[PTR_W-1:0];
    w_rr_nxt = {1'b0, w_gnt} + (PTR_W + 1)'(1);
    if (w_rr_nxt >= NUM_REQ_W) w_rr_nxt = '0;
  end

  // FSM state register: remembers last cycle's operation for the response.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_state;
  end

  // FSM next-state: pick this cycle's single operation by priority.
  always_comb begin
    w_state = ST_IDLE;
    if (!r_alive || flush_i || hold_i) begin
      w_state = ST_IDLE;
    end else if (!w_empty && (!w_any_req || (r_starve < STARVE_MAX))) begin
      w_state = ST_DRAIN;
    end else if (w_any_req) begin
      w_state = ST_CHECK;
    end
  end

  // FSM outputs: buffer write/lookup strobes, grant, registered response.
  always_comb begin
    rec_ready_o      = r_alive & ~w_full;
    buf_en_write_o   = (w_state == ST_DRAIN);
    buf_addr_first_o = '0;
    buf_addr_last_o  = '0;
    if (w_state == ST_DRAIN) begin
      buf_addr_first_o = r_mem_first[r_rd_ptr[AW-1:0]];
      buf_addr_last_o  = r_mem_last[r_rd_ptr[AW-1:0]];
    end
    chk_ready_o     = '0;
    buf_find_o      = 1'b0;
    buf_find_addr_o = '0;
    if (w_state == ST_CHECK) begin
      buf_find_o = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_gnt == PTR_W'(i)) begin
          chk_ready_o[i]  = 1'b1;
          buf_find_addr_o = chk_addr_i[32*i +: 32];
        end
      end
    end
    rsp_valid_o = (r_state == ST_CHECK) ? r_grant : '0;
    rsp_hit_o   = (r_state == ST_CHECK) & r_hit;
    miss_cnt_o  = r_miss;
  end

  // Holds rec_ready_o low until the first clock edge after reset release.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_alive <= 1'b0;
    else         r_alive <= 1'b1;
  end

  // FIFO pointers; flush drops all queued entries but keeps a same-cycle push.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW + 1)'(1);
      if (flush_i)                    r_rd_ptr <= r_wr_ptr;
      else if (w_state == ST_DRAIN)   r_rd_ptr <= r_rd_ptr + (AW + 1)'(1);
    end
  end

  // FIFO storage.
  // NOTE: the record array is deliberately not reset; the pointers define
  // which entries are valid, so clearing the data would only cost logic.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem_first[r_wr_ptr[AW-1:0]] <= rec_first_i;
      r_mem_last[r_wr_ptr[AW-1:0]]  <= rec_last_i;
    end
  end

  // Arbitration state: round-robin pointer and consecutive-write counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr     <= '0;
      r_starve <= '0;
    end else begin
      if (w_state == ST_CHECK) r_rr <= w_rr_nxt[PTR_W-1:0];
      if (flush_i || !w_any_req || (w_state == ST_CHECK)) begin
        r_starve <= '0;
      end else if ((w_state == ST_DRAIN) && (r_starve < STARVE_MAX)) begin
        r_starve <= r_starve + SW'(1);
      end
    end
  end

  // Response pipeline and saturating miss counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_grant <= '0;
      r_hit   <= 1'b0;
      r_miss  <= '0;
    end else begin
      r_grant <= chk_ready_o;
      r_hit   <= (w_state == ST_CHECK) & buf_addr_in_range_i;
      if ((w_state == ST_CHECK) && !buf_addr_in_range_i && (r_miss != 16'hFFFF))
        r_miss <= r_miss + 16'd1;
    end
  end

endmodule

// File: tb/tb_range_check_arbiter.sv
// Self-checking bench for range_check_arbiter: directed scenarios plus a
// randomized run, checked by a queue-based reference model and a monitor.
`timescale 1ns/1ps

module tb_range_check_arbiter;

  localparam int NR    = 2;
  localparam int DEPTH = 4;
  localparam int LIM   = 4;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            flush_i, hold_i, rec_valid_i, rec_ready_o;
  logic [31:0]     rec_first_i, rec_last_i;
  logic [NR-1:0]   chk_valid_i, chk_ready_o, rsp_valid_o;
  logic [32*NR-1:0] chk_addr_i;
  logic            rsp_hit_o;
  logic [15:0]     miss_cnt_o;
  logic            buf_en_write_o, buf_find_o, buf_addr_in_range_i;
  logic [31:0]     buf_addr_first_o, buf_addr_last_o, buf_find_addr_o;

  always #5 clk_i = ~clk_i;

  range_check_arbiter #(.NUM_REQ(NR), .REC_FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIM)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .hold_i(hold_i),
    .rec_valid_i(rec_valid_i), .rec_ready_o(rec_ready_o),
    .rec_first_i(rec_first_i), .rec_last_i(rec_last_i),
    .chk_valid_i(chk_valid_i), .chk_ready_o(chk_ready_o), .chk_addr_i(chk_addr_i),
    .rsp_valid_o(rsp_valid_o), .rsp_hit_o(rsp_hit_o), .miss_cnt_o(miss_cnt_o),
    .buf_en_write_o(buf_en_write_o), .buf_addr_first_o(buf_addr_first_o),
    .buf_addr_last_o(buf_addr_last_o), .buf_find_o(buf_find_o),
    .buf_find_addr_o(buf_find_addr_o), .buf_addr_in_range_i(buf_addr_in_range_i)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit run = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Range buffer environment: stores what the DUT writes, answers lookups.
  logic [31:0] b_first [4096];
  logic [31:0] b_last  [4096];
  int b_cnt = 0;
  always @(posedge clk_i) begin
    if (rst_ni && buf_en_write_o && b_cnt < 4096) begin
      b_first[b_cnt] <= buf_addr_first_o;
      b_last[b_cnt]  <= buf_addr_last_o;
      b_cnt <= b_cnt + 1;
    end
  end
  always @(buf_find_addr_o or b_cnt) begin
    buf_addr_in_range_i = 1'b0;
    for (int i = 0; i < b_cnt; i++)
      if (buf_find_addr_o >= b_first[i] && buf_find_addr_o <= b_last[i])
        buf_addr_in_range_i = 1'b1;
  end

  // Reference model: pending records, written ranges, pointers, scoreboards.
  typedef struct {
    int          cyc;
    int          idx;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        hit;
    logic [15:0] miss;
  } exp_t;

  logic [31:0] m_q_first[$], m_q_last[$];
  logic [31:0] m_r_first[$], m_r_last[$];
  int          m_rr = 0, m_starve = 0;
  int          m_miss = 0;
  bit          m_exp_ready;
  exp_t        wr_q[$], gnt_q[$], rsp_q[$];

  function automatic bit m_in_range(input logic [31:0] a);
    for (int i = 0; i < m_r_first.size(); i++)
      if (a >= m_r_first[i] && a <= m_r_last[i]) return 1'b1;
    return 1'b0;
  endfunction

  always @(negedge clk_i) begin
    if (run) begin
      automatic bit   any = |chk_valid_i;
      automatic bit   push;
      automatic int   g = -1;
      automatic exp_t e;
      m_exp_ready = (m_q_first.size() < DEPTH);
      push = rec_valid_i && m_exp_ready;
      if (flush_i) begin
        m_q_first.delete(); m_q_last.delete();
        m_starve = 0;
      end else if (hold_i) begin
        if (!any) m_starve = 0;
      end else if (m_q_first.size() > 0 && (!any || m_starve < LIM)) begin
        e = '{cyc: cyc, idx: 0, d0: m_q_first[0], d1: m_q_last[0], hit: 1'b0, miss: 16'd0};
        wr_q.push_back(e);
        m_r_first.push_back(m_q_first.pop_front());
        m_r_last.push_back(m_q_last.pop_front());
        m_starve = any ? m_starve + 1 : 0;
      end else if (any) begin
        for (int k = 0; k < NR; k++)
          if (g < 0 && chk_valid_i[(m_rr + k) % NR]) g = (m_rr + k) % NR;
        e.cyc = cyc; e.idx = g; e.d0 = chk_addr_i[32*g +: 32]; e.d1 = 0;
        e.hit = m_in_range(e.d0);
        if (!e.hit && m_miss < 65535) m_miss++;
        e.miss = 16'(m_miss);
        gnt_q.push_back(e);
        e.cyc = cyc + 1;
        rsp_q.push_back(e);
        m_rr = (g + 1) % NR;
        m_starve = 0;
      end else begin
        m_starve = 0;
      end
      if (push) begin
        m_q_first.push_back(rec_first_i);
        m_q_last.push_back(rec_last_i);
      end
    end
  end

  // Monitor: compares DUT outputs against the scoreboard every cycle.
  int run_len = 0, max_run = 0;
  initial forever begin
    @(negedge clk_i);
    #1;
    if (run) begin
      automatic bit         w_due = (wr_q.size() > 0 && wr_q[0].cyc == cyc);
      automatic bit         g_due = (gnt_q.size() > 0 && gnt_q[0].cyc == cyc);
      automatic bit         r_due = (rsp_q.size() > 0 && rsp_q[0].cyc == cyc);
      automatic logic [NR-1:0] exp_g = g_due ? NR'(1 << gnt_q[0].idx) : '0;
      automatic logic [NR-1:0] exp_r = r_due ? NR'(1 << rsp_q[0].idx) : '0;
      automatic exp_t       e;
      check("rec_ready", rec_ready_o, m_exp_ready);
      check("wr_strobe", buf_en_write_o, w_due);
      if (w_due) begin
        e = wr_q.pop_front();
        check("wr_first", buf_addr_first_o, e.d0);
        check("wr_last", buf_addr_last_o, e.d1);
      end
      check("grant", chk_ready_o, exp_g);
      if (g_due) begin
        e = gnt_q.pop_front();
        check("find", buf_find_o, 1'b1);
        check("find_addr", buf_find_addr_o, e.d0);
      end else begin
        check("find_idle", {buf_find_o, buf_find_addr_o}, 33'd0);
      end
      check("rsp_valid", rsp_valid_o, exp_r);
      if (r_due) begin
        e = rsp_q.pop_front();
        check("rsp_hit", rsp_hit_o, e.hit);
        check("miss_cnt", miss_cnt_o, e.miss);
      end else begin
        check("rsp_hit_idle", rsp_hit_o, 1'b0);
      end
      if (flush_i || chk_ready_o != 0 || chk_valid_i == 0) begin
        run_len = 0;
      end else if (buf_en_write_o) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
        check("starve_bound", run_len <= LIM, 1'b1);
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_idle();
    flush_i = 0; hold_i = 0; rec_valid_i = 0; chk_valid_i = '0;
    rec_first_i = '0; rec_last_i = '0; chk_addr_i = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with stimuli active: every output must stay 0.
    flush_i = 0; hold_i = 0; rec_valid_i = 1; rec_first_i = 32'h10; rec_last_i = 32'h20;
    chk_valid_i = 2'b11; chk_addr_i = {32'h18, 32'h18};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("reset_outputs", {rec_ready_o, chk_ready_o, rsp_valid_o, rsp_hit_o, miss_cnt_o,
             buf_en_write_o, buf_addr_first_o, buf_addr_last_o, buf_find_o, buf_find_addr_o}, '0);
    end
    @(posedge clk_i); #1;
    set_idle();
    rst_ni = 1;
    step();
    run = 1;
    @(negedge clk_i);
    check("post_reset_rec_ready", rec_ready_o, 1'b1);
    check("post_reset_chk_ready", chk_ready_o, 2'b00);
    step();

    // Write-before-check, then a miss.
    rec_valid_i = 1; rec_first_i = 32'h1000; rec_last_i = 32'h10FF;
    step();
    set_idle(); chk_valid_i = 2'b01; chk_addr_i[31:0] = 32'h1080;
    @(negedge clk_i); check("p2_write", buf_en_write_o, 1'b1);
    step();
    @(negedge clk_i); check("p2_grant", chk_ready_o, 2'b01);
    step();
    chk_addr_i[31:0] = 32'h1100;
    @(negedge clk_i);
    check("p2_rsp_valid", rsp_valid_o, 2'b01);
    check("p2_rsp_hit", rsp_hit_o, 1'b1);
    step();
    set_idle();
    step(); step();
    @(negedge clk_i); check("p2_miss_cnt", miss_cnt_o, 16'd1);
    step();

    // Round-robin alternation with both requesters valid.
    chk_valid_i = 2'b10; chk_addr_i = {32'h1010, 32'h2020};
    step();
    chk_valid_i = 2'b11;
    for (int i = 0; i < 6; i++) begin
      chk_addr_i = {$urandom_range(0, 32'h3000), $urandom_range(0, 32'h3000)};
      @(negedge clk_i); check("rr_grant", chk_ready_o, (i % 2) ? 2'b10 : 2'b01);
      step();
    end
    set_idle(); step(); step();

    // Starvation bound: records every cycle while req0 waits.
    max_run = 0;
    for (int i = 0; i < 25; i++) begin
      rec_valid_i = 1; rec_first_i = 32'h4000 + 32'(i) * 32'h40; rec_last_i = rec_first_i + 32'h3F;
      chk_valid_i = 2'b01; chk_addr_i[31:0] = 32'h4000 + 32'($urandom_range(0, 32'h800));
      step();
    end
    check("starve_max_run", max_run, LIM);
    set_idle();
    for (int i = 0; i < 8; i++) step();

    // Full FIFO under hold, then in-order drain.
    hold_i = 1; rec_valid_i = 1;
    for (int i = 0; i < 5; i++) begin
      rec_first_i = 32'h8000 + 32'(i) * 32'h100; rec_last_i = rec_first_i + 32'hFF;
      @(negedge clk_i); check("p5_ready_hold", rec_ready_o, i < 4);
      step();
    end
    set_idle();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      check("p5_write", buf_en_write_o, 1'b1);
      check("p5_order", buf_addr_first_o, 32'h8000 + 32'(i) * 32'h100);
      check("p5_ready_drain", rec_ready_o, i != 0);
      step();
    end
    step();

    // Flush with records queued and a response in flight.
    hold_i = 1; rec_valid_i = 1;
    for (int i = 0; i < 4; i++) begin
      rec_first_i = 32'h9000 + 32'(i) * 32'h10; rec_last_i = rec_first_i + 32'hF;
      step();
    end
    hold_i = 0; chk_valid_i = 2'b01; chk_addr_i = {32'h9005, 32'h9005};
    for (int i = 0; i < 4; i++) begin
      rec_first_i = 32'hA000 + 32'(i) * 32'h10; rec_last_i = rec_first_i + 32'hF;
      @(negedge clk_i); check("p6_drain", buf_en_write_o, 1'b1);
      step();
    end
    rec_valid_i = 0;
    @(negedge clk_i); check("p6_grant", chk_ready_o, 2'b01);
    step();
    flush_i = 1; chk_valid_i = 2'b11;
    @(negedge clk_i);
    check("p6_rsp_through_flush", rsp_valid_o, 2'b01);
    check("p6_no_write_flush", buf_en_write_o, 1'b0);
    check("p6_no_grant_flush", chk_ready_o, 2'b00);
    step();
    flush_i = 0;
    @(negedge clk_i);
    check("p6_successor_grant", chk_ready_o, 2'b10);
    check("p6_fifo_empty", buf_en_write_o, 1'b0);
    step();
    set_idle(); step(); step();

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      rec_valid_i = 1'($urandom);
      rec_first_i = $urandom_range(0, 32'hFFF00);
      rec_last_i  = rec_first_i + $urandom_range(0, 255);
      chk_valid_i = 2'($urandom);
      chk_addr_i  = {$urandom_range(0, 32'hFFFFF), $urandom_range(0, 32'hFFFFF)};
      hold_i      = ($urandom_range(0, 9) == 0);
      flush_i     = ($urandom_range(0, 29) == 0);
      step();
    end
    set_idle();
    for (int i = 0; i < 10; i++) step();
    @(negedge clk_i); #2;
    run = 0;
    check("wr_queue_drained", wr_q.size(), 0);
    check("grant_queue_drained", gnt_q.size(), 0);
    check("rsp_queue_drained", rsp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/range_check_arbiter.md
Name: range_check_arbiter

Overview:
- Sequences the allocated-range buffer, which stores {first,last} address pairs and does combinational range lookups.
- Buffers allocation records from the instrumentation path and drains them into the buffer one per cycle.
- Shares the buffer's single lookup port among NUM_REQ checkers (e.g. load and store units) using round-robin arbitration.
- Returns a registered in-range verdict, and guarantees lookups are not starved by record writes.

Parameters:
NUM_REQ, 2, number of lookup requesters (1..4)
REC_FIFO_DEPTH, 4, record FIFO entries (power of 2, >=2)
STARVE_LIMIT, 4, max consecutive write cycles while any lookup is pending (>=1)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
flush_i  in  1  sync clear of record FIFO and arbitration state
hold_i  in  1  freeze: no writes, no grants while high
rec_valid_i  in  1  allocation record valid
rec_ready_o  out  1  record accepted when valid&ready
rec_first_i  in  32  range start address
rec_last_i  in  32  range end address (inclusive)
chk_valid_i  in  NUM_REQ  lookup request per requester
chk_ready_o  out  NUM_REQ  one-hot grant; request consumed this cycle
chk_addr_i  in  32*NUM_REQ  lookup address, requester i at [32i+31:32i]
rsp_valid_o  out  NUM_REQ  one-hot response strobe
rsp_hit_o  out  1  1 = address inside a stored range
miss_cnt_o  out  16  saturating count of lookups with hit=0
buf_en_write_o  out  1  buffer write strobe
buf_addr_first_o  out  32  record start to buffer
buf_addr_last_o  out  32  record end to buffer
buf_find_o  out  1  lookup active
buf_find_addr_o  out  32  lookup address to buffer
buf_addr_in_range_i  in  1  combinational lookup result from buffer

Behaviour:
- Reset values:
  - All outputs are 0; rec_ready_o is 0 during reset and 1 from the first cycle after it.
  - FIFO is empty, RR pointer points to requester 0, starve_cnt=0, state=IDLE.
- Record FIFO:
  - rec_ready_o = !full; there is no pass-through when full.
  - A push and a pop in the same cycle are both allowed. Ordering is FIFO.
- Exactly one operation per cycle, decided combinationally from the registered state plus inputs.
- States:
  - IDLE: FIFO empty and no chk_valid_i.
  - DRAIN: pop FIFO head, buf_en_write_o=1, head on buf_addr_*.
  - CHECK: grant one requester.
- Decision priority, highest first:
  1. rst_ni low.
  2. flush_i: FIFO emptied, no write, no grant, starve_cnt=0.
  3. hold_i: nothing happens; pushes are still accepted.
  4. FIFO non-empty and (no chk_valid_i, or starve_cnt<STARVE_LIMIT): DRAIN.
  5. Any chk_valid_i: CHECK.
  6. Otherwise: IDLE.
- Coherency: a lookup granted in cycle N sees every record written in cycles < N. Records still in the FIFO are not visible.
- starve_cnt:
  - Increments on each DRAIN cycle with any chk_valid_i high.
  - Clears on a CHECK cycle, and on any cycle with no chk_valid_i.
  - Never exceeds STARVE_LIMIT.
- CHECK:
  - Grant the first valid requester at or after rr_ptr, cyclically.
  - In the same cycle: chk_ready_o[g]=1, buf_find_o=1, buf_find_addr_o=chk_addr_i[g].
  - rr_ptr <= g+1 modulo NUM_REQ.
  - buf_find_addr_o is 0 when not in CHECK.
- Response:
  - Latency is 1 cycle after the grant: rsp_valid_o[g]=1 and rsp_hit_o = registered buf_addr_in_range_i.
  - At most one response bit per cycle.
  - rsp_hit_o is 0 when no response.
  - A response already in flight is delivered even if flush_i or hold_i asserts.
- miss_cnt_o increments with each response where hit=0 and saturates at 0xFFFF. flush_i does not clear it.
- Async reset mid-operation: the in-flight response is dropped and FIFO contents are lost.

Test Plan:
1. Reset: hold rst_ni low 3 cycles with stimuli active -> all outputs 0. First cycle after release: rec_ready_o=1, chk_ready_o=0.
2. Write-before-check:
   - Push {0x1000,0x10FF} in cycle 0 while req0 requests 0x1080.
   - Cycle 1: buf_en_write_o=1.
   - Cycle 2: chk_ready_o=01.
   - Cycle 3: rsp_valid_o=01, rsp_hit_o=1.
   - Then a lookup of 0x1100 -> hit=0, miss_cnt_o=1.
3. Round-robin: FIFO empty, both requesters valid continuously for 6 cycles -> grants 01,10,01,10,01,10. Responses follow each grant by 1 cycle.
4. Starvation: push a record every cycle while req0 is held valid -> pattern of exactly 4 DRAIN cycles then 1 CHECK, repeating.
5. Full/hold:
   - hold_i=1, offer 5 records -> 4 accepted, rec_ready_o=0 on the 5th.
   - Release hold_i -> 4 consecutive writes in push order. rec_ready_o returns to 1 after the first pop.
6. Flush:
   - With 3 records queued and a grant just issued, pulse flush_i.
   - Required: the response is still delivered next cycle, there are no writes, the FIFO is empty, and the following grant goes to rr_ptr's successor.
